// File: rtl/regb_fifo_pkg.sv
// rtl/regb_fifo_pkg.sv - shared types and helpers for the register-based FIFO chain
package regb_fifo_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Ceiling log2, used to size counters and pointers
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - one-hot pick of the first request at or after a pointer
module rr_pick
    import regb_fifo_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [PW-1:0] idx;
    logic          found;

    // Scan from ptr upward with wrap; first asserted request wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regb_fifo_arbiter.sv
// rtl/regb_fifo_arbiter.sv - round-robin write arbiter with burst lock and FIFO level tracking
module regb_fifo_arbiter
    import regb_fifo_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 8,
    localparam int LW     = clog2(DEPTH + 1),
    localparam int PW     = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_shift_out,
    output logic [WIDTH-1:0]           fifo_si,
    output logic                       fifo_shift_in,
    output logic [LW-1:0]              fifo_level,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic                       underflow_err
);

    arb_state_t        state, state_nxt;
    logic [PW-1:0]     rr_ptr, rr_ptr_nxt;
    logic [PW-1:0]     owner, owner_nxt;
    logic [PW-1:0]     gnt_idx;
    logic [NUM_REQ-1:0] pick_grant;
    logic [LW-1:0]     level;
    logic              err;
    logic              push;

    function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] i);
        return (i == PW'(NUM_REQ - 1)) ? '0 : i + PW'(1);
    endfunction

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant)
    );

    assign fifo_full     = (level == LW'(DEPTH));
    assign fifo_empty    = (level == '0);
    assign fifo_level    = level;
    assign underflow_err = err;

    // Grant: round-robin when idle, owner only while locked, nothing when full
    always_comb begin
        req_ready = '0;
        if (!fifo_full) begin
            case (state)
                IDLE:    req_ready = pick_grant;
                LOCKED:  req_ready[owner] = req_valid[owner];
                default: req_ready = '0;
            endcase
        end
    end

    // Encode granted index and steer its word to the chain input
    always_comb begin
        gnt_idx = '0;
        fifo_si = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                gnt_idx = PW'(i);
                fifo_si = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign push          = |(req_valid & req_ready);
    assign fifo_shift_in = push;

    // Next-state: lock on a non-last beat, release and advance pointer on the last beat
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        if (push) begin
            case (state)
                IDLE: begin
                    if (req_last[gnt_idx]) begin
                        rr_ptr_nxt = nxt_ptr(gnt_idx);
                    end else begin
                        state_nxt = LOCKED;
                        owner_nxt = gnt_idx;
                    end
                end
                LOCKED: begin
                    if (req_last[owner]) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = nxt_ptr(owner);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Arbitration state registers; reset drops any burst lock
    always_ff @(posedge clk) begin
        if (res) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            owner  <= owner_nxt;
        end
    end

    // Occupancy counter and sticky underflow flag
    always_ff @(posedge clk) begin
        if (res) begin
            level <= '0;
            err   <= 1'b0;
        end else begin
            if (push && !fifo_shift_out) begin
                level <= level + LW'(1);
            end else if (!push && fifo_shift_out && !fifo_empty) begin
                level <= level - LW'(1);
            end
            if (fifo_shift_out && fifo_empty) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regb_fifo_arbiter.sv
// tb/tb_regb_fifo_arbiter.sv - directed vector bench for regb_fifo_arbiter
module tb_regb_fifo_arbiter;

    logic        clk;
    logic        res;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_shift_out;
    logic [7:0]  fifo_si;
    logic        fifo_shift_in;
    logic [2:0]  fifo_level;
    logic        fifo_full;
    logic        fifo_empty;
    logic        underflow_err;

    int n_pass;
    int n_total;

    typedef struct {
        logic       res;
        logic [3:0] v;
        logic [3:0] l;
        logic       p;
        logic [3:0] rdy;
        logic [7:0] si;
        logic       sh;
        logic [2:0] lvl;
        logic       f;
        logic       e;
        logic       err;
    } vec_t;

    vec_t tbl [26];

    regb_fifo_arbiter #(.WIDTH(8), .NUM_REQ(4), .DEPTH(4)) dut (
        .clk            (clk),
        .res            (res),
        .req_valid      (req_valid),
        .req_last       (req_last),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .fifo_shift_out (fifo_shift_out),
        .fifo_si        (fifo_si),
        .fifo_shift_in  (fifo_shift_in),
        .fifo_level     (fifo_level),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .underflow_err  (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l, input logic p,
                                input logic [3:0] rdy, input logic [7:0] si, input logic sh,
                                input logic [2:0] lvl, input logic f, input logic e, input logic err);
        vec_t t;
        t.res = r; t.v = v; t.l = l; t.p = p; t.rdy = rdy; t.si = si; t.sh = sh;
        t.lvl = lvl; t.f = f; t.e = e; t.err = err;
        return t;
    endfunction

    task automatic check(input string name, input int step, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of inputs after the falling edge, then compare settled outputs
    task automatic apply(input vec_t t, input int step);
        @(negedge clk);
        res            = t.res;
        req_valid      = t.v;
        req_last       = t.l;
        fifo_shift_out = t.p;
        #1;
        check("req_ready",     step, {4'b0, req_ready},     {4'b0, t.rdy});
        check("fifo_si",       step, fifo_si,               t.si);
        check("fifo_shift_in", step, {7'b0, fifo_shift_in}, {7'b0, t.sh});
        check("fifo_level",    step, {5'b0, fifo_level},    {5'b0, t.lvl});
        check("fifo_full",     step, {7'b0, fifo_full},     {7'b0, t.f});
        check("fifo_empty",    step, {7'b0, fifo_empty},    {7'b0, t.e});
        check("underflow_err", step, {7'b0, underflow_err}, {7'b0, t.err});
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        //            res  valid    last     pop   ready    si     sh  lvl  f  e  err
        tbl[0]  = mk(0, 4'b0000, 4'b1111, 0, 4'b0000, 8'h00, 0, 3'd0, 0, 1, 0);
        tbl[1]  = mk(0, 4'b0001, 4'b1111, 0, 4'b0001, 8'hA0, 1, 3'd0, 0, 1, 0);
        tbl[2]  = mk(0, 4'b0000, 4'b1111, 0, 4'b0000, 8'h00, 0, 3'd1, 0, 0, 0);
        tbl[3]  = mk(0, 4'b1111, 4'b1111, 1, 4'b0010, 8'hA1, 1, 3'd1, 0, 0, 0);
        tbl[4]  = mk(0, 4'b1111, 4'b1111, 1, 4'b0100, 8'hA2, 1, 3'd1, 0, 0, 0);
        tbl[5]  = mk(0, 4'b1111, 4'b1111, 1, 4'b1000, 8'hA3, 1, 3'd1, 0, 0, 0);
        tbl[6]  = mk(0, 4'b1111, 4'b1111, 1, 4'b0001, 8'hA0, 1, 3'd1, 0, 0, 0);
        tbl[7]  = mk(0, 4'b1111, 4'b1111, 1, 4'b0010, 8'hA1, 1, 3'd1, 0, 0, 0);
        tbl[8]  = mk(0, 4'b1111, 4'b1011, 1, 4'b0100, 8'hA2, 1, 3'd1, 0, 0, 0);
        tbl[9]  = mk(0, 4'b1011, 4'b1011, 0, 4'b0000, 8'h00, 0, 3'd1, 0, 0, 0);
        tbl[10] = mk(0, 4'b1111, 4'b1011, 1, 4'b0100, 8'hA2, 1, 3'd1, 0, 0, 0);
        tbl[11] = mk(0, 4'b1111, 4'b1111, 1, 4'b0100, 8'hA2, 1, 3'd1, 0, 0, 0);
        tbl[12] = mk(0, 4'b1111, 4'b1111, 0, 4'b1000, 8'hA3, 1, 3'd1, 0, 0, 0);
        tbl[13] = mk(0, 4'b1111, 4'b1111, 0, 4'b0001, 8'hA0, 1, 3'd2, 0, 0, 0);
        tbl[14] = mk(0, 4'b1111, 4'b1111, 0, 4'b0010, 8'hA1, 1, 3'd3, 0, 0, 0);
        tbl[15] = mk(0, 4'b1111, 4'b1111, 0, 4'b0000, 8'h00, 0, 3'd4, 1, 0, 0);
        tbl[16] = mk(0, 4'b1111, 4'b1111, 1, 4'b0000, 8'h00, 0, 3'd4, 1, 0, 0);
        tbl[17] = mk(0, 4'b1111, 4'b1111, 0, 4'b0100, 8'hA2, 1, 3'd3, 0, 0, 0);
        tbl[18] = mk(0, 4'b0000, 4'b1111, 1, 4'b0000, 8'h00, 0, 3'd4, 1, 0, 0);
        tbl[19] = mk(0, 4'b0000, 4'b1111, 1, 4'b0000, 8'h00, 0, 3'd3, 0, 0, 0);
        tbl[20] = mk(0, 4'b0000, 4'b1111, 1, 4'b0000, 8'h00, 0, 3'd2, 0, 0, 0);
        tbl[21] = mk(0, 4'b0000, 4'b1111, 1, 4'b0000, 8'h00, 0, 3'd1, 0, 0, 0);
        tbl[22] = mk(0, 4'b0000, 4'b1111, 1, 4'b0000, 8'h00, 0, 3'd0, 0, 1, 0);
        tbl[23] = mk(0, 4'b0000, 4'b1111, 0, 4'b0000, 8'h00, 0, 3'd0, 0, 1, 1);
        tbl[24] = mk(0, 4'b0001, 4'b1111, 0, 4'b0001, 8'hA0, 1, 3'd0, 0, 1, 1);
        tbl[25] = mk(0, 4'b0000, 4'b1111, 0, 4'b0000, 8'h00, 0, 3'd1, 0, 0, 1);

        res            = 1'b1;
        req_valid      = '0;
        req_last       = '0;
        fifo_shift_out = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 26; i++) begin
            apply(tbl[i], i);
        end

        // Start a burst from requester 2, reset mid-burst, then requester 0 must win
        apply(mk(0, 4'b0100, 4'b0000, 0, 4'b0100, 8'hA2, 1, 3'd1, 0, 0, 1), 100);
        apply(mk(1, 4'b0101, 4'b1111, 0, 4'b0100, 8'hA2, 1, 3'd2, 0, 0, 1), 101);
        apply(mk(0, 4'b0101, 4'b1111, 0, 4'b0001, 8'hA0, 1, 3'd0, 0, 1, 0), 102);
        apply(mk(0, 4'b0000, 4'b1111, 0, 4'b0000, 8'h00, 0, 3'd1, 0, 0, 0), 103);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
